alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_mul_iter.sv | 48 ++++
 rtl/alu_mc.sv | 154 +++++++++++++++
 tb/tb_alu_mc.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants and FSM state encoding shared by the ALU files
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_NAND = 3'b101,
    OP_NOR  = 3'b110,
    OP_XOR  = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - unsigned shift-add multiplier, one partial product per step
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           load_i,
  input  logic           step_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] product_o,
  output logic           last_o
);

  localparam int CW = $clog2(W) + 1;

  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplier_q;
  logic [2*W-1:0] acc_q;
  logic [CW-1:0]  cnt_q;

  // Accumulator including the partial product of the current step, so the
  // final step's product is available in the same cycle it is added.
  assign product_o = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last_o    = (cnt_q == CW'(W - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (load_i) begin
      mcand_q  <= {{W{1'b0}}, a_i};
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (step_i) begin
      acc_q    <= product_o;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with registered result and flags
// Defining ALU_OVF_EN adds the signed overflow output for ADD/SUB.
module alu_mc
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   port_a,
  input  logic [DATA_WIDTH-1:0]   port_b,
  input  logic [2:0]              selector,
  output logic                    ready,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] out,
  output logic                    carry,
  output logic                    zero,
  output logic                    negativo
`ifdef ALU_OVF_EN
  ,
  output logic                    overflow
`endif
);

  localparam int W = DATA_WIDTH;

  state_e         state_q;
  logic [2*W-1:0] out_q;
  logic           carry_q, zero_q, neg_q, done_q, ready_q;

  opcode_e        op;
  logic [W:0]     sum, diff;
  logic [W-1:0]   low_res;
  logic [2*W-1:0] alu_out;
  logic           alu_carry;

  logic           mul_load, mul_step, mul_last;
  logic [2*W-1:0] mul_prod;

  assign op = opcode_e'(selector);

  // The extra MSB of the widened subtraction is the unsigned borrow.
  always_comb begin
    sum       = {1'b0, port_a} + {1'b0, port_b};
    diff      = {1'b0, port_a} - {1'b0, port_b};
    low_res   = '0;
    alu_carry = 1'b0;
    case (op)
      OP_ADD:  begin low_res = sum[W-1:0];  alu_carry = sum[W];  end
      OP_SUB:  begin low_res = diff[W-1:0]; alu_carry = diff[W]; end
      OP_AND:  low_res = port_a & port_b;
      OP_OR:   low_res = port_a | port_b;
      OP_NAND: low_res = ~(port_a & port_b);
      OP_NOR:  low_res = ~(port_a | port_b);
      OP_XOR:  low_res = port_a ^ port_b;
      default: low_res = '0;
    endcase
    alu_out = {{W{1'b0}}, low_res};
  end

`ifdef ALU_OVF_EN
  logic alu_ovf, ovf_q;

  always_comb begin
    alu_ovf = 1'b0;
    if (op == OP_ADD)
      alu_ovf = (port_a[W-1] == port_b[W-1]) && (sum[W-1] != port_a[W-1]);
    else if (op == OP_SUB)
      alu_ovf = (port_a[W-1] != port_b[W-1]) && (diff[W-1] != port_a[W-1]);
  end

  assign overflow = ovf_q;
`endif

  assign mul_load = (state_q == ST_IDLE) && start && (op == OP_MUL);
  assign mul_step = (state_q == ST_MUL);

  alu_mul_iter #(.W(W)) u_mul (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (mul_load),
    .step_i    (mul_step),
    .a_i       (port_a),
    .b_i       (port_b),
    .product_o (mul_prod),
    .last_o    (mul_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
`ifdef ALU_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && op == OP_MUL) begin
            state_q <= ST_MUL;
            ready_q <= 1'b0;
          end else if (start) begin
            state_q <= ST_DONE;
            ready_q <= 1'b0;
            done_q  <= 1'b1;
            out_q   <= alu_out;
            carry_q <= alu_carry;
            zero_q  <= (alu_out == '0);
            neg_q   <= alu_out[W-1];
`ifdef ALU_OVF_EN
            ovf_q   <= alu_ovf;
`endif
          end
        end
        ST_MUL: begin
          if (mul_last) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            out_q   <= mul_prod;
            carry_q <= 1'b0;
            zero_q  <= (mul_prod == '0);
            neg_q   <= mul_prod[2*W-1];
`ifdef ALU_OVF_EN
            ovf_q   <= 1'b0;
`endif
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign out      = out_q;
  assign carry    = carry_q;
  assign zero     = zero_q;
  assign negativo = neg_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - randomized bench for alu_mc against a cycle-count reference model
module tb_alu_mc;

  localparam int W = 8;

  logic          clk, rst, start;
  logic [W-1:0]  port_a, port_b;
  logic [2:0]    selector;
  logic          ready, done, carry, zero, negativo;
  logic [2*W-1:0] out;
`ifdef ALU_OVF_EN
  logic          overflow;
`endif

  int checks = 0;
  int failures = 0;

  alu_mc #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .port_a   (port_a),
    .port_b   (port_b),
    .selector (selector),
    .ready    (ready),
    .done     (done),
    .out      (out),
    .carry    (carry),
    .zero     (zero),
    .negativo (negativo)
`ifdef ALU_OVF_EN
    ,
    .overflow (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from plain integer arithmetic.
  function automatic void ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 output logic [15:0] r, output bit c, output bit n, output bit o);
    int ia, ib, sa, sb, s;
    ia = a; ib = b;
    sa = (ia > 127) ? ia - 256 : ia;
    sb = (ib > 127) ? ib - 256 : ib;
    c = 0; o = 0;
    case (op)
      3'd0: begin s = ia + ib; r = 16'(s % 256); c = (s > 255);
                  o = ((sa + sb) > 127) || ((sa + sb) < -128); end
      3'd1: begin r = 16'((ia - ib + 256) % 256); c = (ia < ib);
                  o = ((sa - sb) > 127) || ((sa - sb) < -128); end
      3'd2: r = 16'(ia * ib);
      3'd3: r = {8'h00, a & b};
      3'd4: r = {8'h00, a | b};
      3'd5: r = {8'h00, ~(a & b)};
      3'd6: r = {8'h00, ~(a | b)};
      default: r = {8'h00, a ^ b};
    endcase
    n = (op == 3'd2) ? r[15] : r[7];
  endfunction

  // Model state: expected outputs as visible after each rising edge.
  logic [15:0] m_out, p_out;
  bit m_c, m_z, m_n, m_o, m_done, m_ready;
  bit p_c, p_n, p_o;
  bit inflight, chk_en;
  int cyc, done_at, ready_at;

  initial begin
    chk_en = 0; inflight = 0; cyc = 0;
    done_at = 0; ready_at = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_out = '0; m_c = 0; m_z = 0; m_n = 0; m_o = 0;
      m_done = 0; m_ready = 1; inflight = 0; chk_en = 1;
    end else begin
      m_done = 0;
      if (!inflight && start) begin
        ref_op(selector, port_a, port_b, p_out, p_c, p_n, p_o);
        done_at  = cyc + ((selector == 3'd2) ? W : 0);
        ready_at = done_at + 1;
        inflight = 1;
        m_ready  = 0;
      end
      if (inflight && cyc == done_at) begin
        m_done = 1;
        m_out = p_out; m_c = p_c; m_n = p_n; m_o = p_o; m_z = (p_out == 0);
      end else if (inflight && cyc == ready_at) begin
        inflight = 0;
        m_ready  = 1;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", ready, m_ready);
      chk("done", done, m_done);
      chk("out", out, m_out);
      chk("carry", carry, m_c);
      chk("zero", zero, m_z);
      chk("negativo", negativo, m_n);
`ifdef ALU_OVF_EN
      chk("overflow", overflow, m_o);
`endif
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] e_out, input bit e_c, input bit e_z, input bit e_n,
                        input bit e_o, input int e_lat);
    int k;
    chk("pre_ready", ready, 1);
    start = 1; selector = op; port_a = a; port_b = b;
    @(negedge clk);
    start = 0; port_a = 8'($urandom); port_b = 8'($urandom); selector = 3'($urandom);
    k = 1;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
      port_a = 8'($urandom); port_b = 8'($urandom);
    end
    chk("lit_latency", k, e_lat);
    chk("lit_out", out, e_out);
    chk("lit_carry", carry, e_c);
    chk("lit_zero", zero, e_z);
    chk("lit_neg", negativo, e_n);
`ifdef ALU_OVF_EN
    chk("lit_ovf", overflow, e_o);
`else
    if (e_o) k = 0;
`endif
    @(negedge clk);
    chk("post_ready", ready, 1);
    chk("post_done", done, 0);
  endtask

  initial begin
    int k;
    rst = 1; start = 0; port_a = '0; port_b = '0; selector = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_out", out, 0);
    chk("rst_flags", {carry, zero, negativo}, 0);
    rst = 0;
    @(negedge clk);

    run_op(3'd0, 8'h7F, 8'h7F, 16'h00FE, 0, 0, 1, 1, 1);
    run_op(3'd0, 8'h81, 8'h81, 16'h0002, 1, 0, 0, 1, 1);
    run_op(3'd0, 8'h00, 8'h00, 16'h0000, 0, 1, 0, 0, 1);
    run_op(3'd1, 8'h0F, 8'h8F, 16'h0080, 1, 0, 1, 1, 1);
    run_op(3'd1, 8'h81, 8'h81, 16'h0000, 0, 1, 0, 0, 1);
    run_op(3'd2, 8'h7F, 8'h7F, 16'h3F01, 0, 0, 0, 0, 9);
    run_op(3'd2, 8'h00, 8'h8F, 16'h0000, 0, 1, 0, 0, 9);
    run_op(3'd2, 8'hFF, 8'hFF, 16'hFE01, 0, 0, 1, 0, 9);
    run_op(3'd5, 8'hFF, 8'hFF, 16'h0000, 0, 1, 0, 0, 1);
    run_op(3'd6, 8'h00, 8'h00, 16'h00FF, 0, 0, 1, 0, 1);
    run_op(3'd7, 8'hA5, 8'h0F, 16'h00AA, 0, 0, 1, 0, 1);

    // start held high with changing operands while a MUL runs
    start = 1; selector = 3'd2; port_a = 8'h7F; port_b = 8'h7F;
    @(negedge clk);
    selector = 3'd0;
    k = 1;
    while (!done && k < 40) begin
      port_a = 8'($urandom); port_b = 8'($urandom);
      @(negedge clk);
      k++;
    end
    chk("hold_latency", k, 9);
    chk("hold_out", out, 16'h3F01);
    @(negedge clk);
    chk("hold_ready", ready, 1);
    chk("hold_out2", out, 16'h3F01);
    start = 0;
    @(negedge clk);
    chk("hold_nodone", done, 0);

    // reset in the middle of a MUL
    start = 1; selector = 3'd2; port_a = 8'h03; port_b = 8'h05;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    rst = 1; start = 1;
    @(negedge clk);
    rst = 0; start = 0;
    chk("abort_out", out, 0);
    chk("abort_flags", {carry, zero, negativo}, 0);
    chk("abort_ready", ready, 1);
    chk("abort_done", done, 0);
    repeat (12) begin
      @(negedge clk);
      chk("abort_nodone", done, 0);
    end

    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 79) == 0);
      start    = ($urandom_range(0, 3) != 0);
      port_a   = 8'($urandom);
      port_b   = 8'($urandom);
      selector = 3'($urandom);
      @(negedge clk);
    end
    rst = 0; start = 0;
    repeat (12) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
